// File: rtl/dlx_control_fsm_if.sv
// Handshake and control bundle between the DLX sequencer and its datapath.
// The sequencer attaches through the slave modport, the datapath through master.
interface dlx_control_fsm_if;
    logic [5:0]  opcode;
    logic [10:0] opcodeALU;
    logic        mem_ready;
    logic        alu_zero;
    logic        IRload;
    logic        IRoeS1;
    logic        IRoeS2;
    logic        pc_inc;
    logic        PCload;
    logic        mem_read;
    logic        mem_write;
    logic        Aload;
    logic        Bload;
    logic        reg_write;
    logic        wb_sel_mem;
    logic [2:0]  ALUop;
    logic [2:0]  state;
    logic        halted;
    logic        bus_error;
    logic        illegal;
    logic [31:0] instr_count;

    modport slave (
        input  opcode, opcodeALU, mem_ready, alu_zero,
        output IRload, IRoeS1, IRoeS2, pc_inc, PCload,
        output mem_read, mem_write, Aload, Bload,
        output reg_write, wb_sel_mem, ALUop, state,
        output halted, bus_error, illegal, instr_count
    );

    modport master (
        output opcode, opcodeALU, mem_ready, alu_zero,
        input  IRload, IRoeS1, IRoeS2, pc_inc, PCload,
        input  mem_read, mem_write, Aload, Bload,
        input  reg_write, wb_sel_mem, ALUop, state,
        input  halted, bus_error, illegal, instr_count
    );
endinterface

// File: rtl/dlx_control_fsm.sv
// Multi-cycle DLX control sequencer: fetch, decode, execute, memory, write-back.
// Strobes decode from the registered state; IRload/pc_inc also follow mem_ready.
module dlx_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic              clock,
    input logic              reset,
    dlx_control_fsm_if.slave bus
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e      state_q;
    logic [5:0]  op_q;
    logic [5:0]  fn_q;
    logic [TW-1:0] tmo_q;
    logic [31:0] cnt_q;
    logic        ill_q;
    logic        berr_q;

    logic        dec_ok;
    logic        fn_ok;
    logic [2:0]  fn_alu;
    logic        unused_fn_hi;

    assign unused_fn_hi = ^bus.opcodeALU[10:6];

    assign dec_ok = bus.opcode inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQZ, OP_J};

    always_comb begin
        fn_ok  = 1'b1;
        fn_alu = ALU_ADD;
        unique case (fn_q)
            6'h20:   fn_alu = ALU_ADD;
            6'h22:   fn_alu = ALU_SUB;
            6'h24:   fn_alu = ALU_AND;
            6'h25:   fn_alu = ALU_OR;
            6'h26:   fn_alu = ALU_XOR;
            default: fn_ok  = 1'b0;
        endcase
    end

    // FETCH and MEM share the wait/timeout logic; only their exit differs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            fn_q    <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    tmo_q   <= '0;
                end
                S_FETCH, S_MEM: begin
                    if (bus.mem_ready) begin
                        tmo_q <= '0;
                        if (state_q == S_FETCH) begin
                            state_q <= S_DECODE;
                        end else if (op_q == OP_LW) begin
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_FETCH;
                            cnt_q   <= cnt_q + 32'd1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (tmo_q == TMO_LAST) begin
                            state_q <= S_HALT;
                            berr_q  <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    op_q <= bus.opcode;
                    fn_q <= bus.opcodeALU[5:0];
                    if (dec_ok) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_HALT;
                        if (bus.opcode != OP_HALT) ill_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    tmo_q <= '0;
                    unique case (1'b1)
                        op_q == OP_R: begin
                            if (fn_ok) begin
                                state_q <= S_WB;
                            end else begin
                                state_q <= S_HALT;
                                ill_q   <= 1'b1;
                            end
                        end
                        op_q == OP_ADDI: state_q <= S_WB;
                        op_q == OP_LW || op_q == OP_SW: state_q <= S_MEM;
                        op_q == OP_BEQZ || op_q == OP_J: begin
                            state_q <= S_FETCH;
                            cnt_q   <= cnt_q + 32'd1;
                        end
                        default: begin
                            state_q <= S_HALT;
                            ill_q   <= 1'b1;
                        end
                    endcase
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    tmo_q   <= '0;
                    cnt_q   <= cnt_q + 32'd1;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.IRload     = 1'b0;
        bus.IRoeS1     = 1'b0;
        bus.IRoeS2     = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.PCload     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.Aload      = 1'b0;
        bus.Bload      = 1'b0;
        bus.reg_write  = 1'b0;
        bus.wb_sel_mem = 1'b0;
        bus.ALUop      = ALU_ADD;
        unique case (state_q)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                bus.IRload   = bus.mem_ready;
                bus.pc_inc   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.Aload = 1'b1;
                bus.Bload = 1'b1;
            end
            S_EXEC: begin
                unique case (1'b1)
                    op_q == OP_R: bus.ALUop = fn_alu;
                    op_q == OP_ADDI || op_q == OP_LW || op_q == OP_SW:
                        bus.IRoeS2 = 1'b1;
                    op_q == OP_BEQZ: begin
                        bus.IRoeS1 = 1'b1;
                        bus.PCload = bus.alu_zero;
                    end
                    op_q == OP_J: begin
                        bus.IRoeS1 = 1'b1;
                        bus.PCload = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.mem_read  = (op_q == OP_LW);
                bus.mem_write = (op_q == OP_SW);
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.wb_sel_mem = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.bus_error   = berr_q;
    assign bus.illegal     = ill_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_dlx_control_fsm.sv
// Bench for dlx_control_fsm: directed vector table, hand sequences,
// and random instruction streams checked against a cycle-list model.
module tb_dlx_control_fsm;
    logic clock;
    logic reset;
    dlx_control_fsm_if bus ();

    dlx_control_fsm #(.MEM_TIMEOUT(15)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // strobe word bit positions, ALUop in [2:0]
    localparam logic [13:0] M_IRL = 14'h2000;
    localparam logic [13:0] M_S1  = 14'h1000;
    localparam logic [13:0] M_S2  = 14'h0800;
    localparam logic [13:0] M_PCI = 14'h0400;
    localparam logic [13:0] M_PCL = 14'h0200;
    localparam logic [13:0] M_MR  = 14'h0100;
    localparam logic [13:0] M_MW  = 14'h0080;
    localparam logic [13:0] M_AB  = 14'h0060;
    localparam logic [13:0] M_RW  = 14'h0010;
    localparam logic [13:0] M_WSM = 14'h0008;

    typedef struct {
        logic [2:0]  st;
        logic        rdy;
        logic [13:0] sb;
    } step_t;

    step_t q[$];

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         z;
        int         fw;
        int         mw;
        int         cyc;
        logic [2:0] fin;
        int         ret;
        bit         ill;
        bit         berr;
        logic [2:0] alu;
        bit         pcl;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] strobes_now();
        return {bus.IRload, bus.IRoeS1, bus.IRoeS2, bus.pc_inc, bus.PCload,
                bus.mem_read, bus.mem_write, bus.Aload, bus.Bload,
                bus.reg_write, bus.wb_sel_mem, bus.ALUop};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst state", 32'(bus.state), 32'd0);
        check("rst outputs", 32'({strobes_now(), bus.halted, bus.bus_error, bus.illegal}), 32'd0);
        check("rst count", bus.instr_count, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("first fetch", 32'(bus.state), 32'd1);
    endtask

    // Directed run: waits are applied by counting low cycles spent in FETCH/MEM.
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] c0;
        logic [2:0]  s;
        logic [2:0]  alu_seen;
        bit          pcl_seen;
        bit          done;
        int          cyc, fl, ml;
        bus.opcode    = v.op;
        bus.opcodeALU = {5'd0, v.fn};
        bus.alu_zero  = v.z;
        c0 = bus.instr_count;
        cyc = 0; fl = 0; ml = 0;
        alu_seen = 3'd7; pcl_seen = 1'b0; done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            s = bus.state;
            if (s == 3'd1 || s == 3'd4) begin
                if (s == 3'd1 ? fl < v.fw : ml < v.mw) begin
                    bus.mem_ready = 1'b0;
                    if (s == 3'd1) fl++;
                    else ml++;
                end else begin
                    bus.mem_ready = 1'b1;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (s == 3'd3) begin
                alu_seen = bus.ALUop;
                pcl_seen = bus.PCload;
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
            if (bus.state == 3'd6 || (bus.state == 3'd1 && s != 3'd1)) done = 1'b1;
        end
        check($sformatf("v%0d finished", idx), 32'(done), 32'd1);
        check($sformatf("v%0d cycles", idx), 32'(cyc), 32'(v.cyc));
        check($sformatf("v%0d state", idx), 32'(bus.state), 32'(v.fin));
        check($sformatf("v%0d retired", idx), bus.instr_count - c0, 32'(v.ret));
        check($sformatf("v%0d illegal", idx), 32'(bus.illegal), 32'(v.ill));
        check($sformatf("v%0d bus_error", idx), 32'(bus.bus_error), 32'(v.berr));
        check($sformatf("v%0d aluop", idx), 32'(alu_seen), 32'(v.alu));
        check($sformatf("v%0d pcload", idx), 32'(pcl_seen), 32'(v.pcl));
        if (v.fin == 3'd6) begin
            repeat (3) begin
                @(posedge clock);
                @(negedge clock);
                check($sformatf("v%0d halt hold", idx),
                      32'({bus.state, bus.halted, bus.mem_read, bus.mem_write}),
                      32'({3'd6, 1'b1, 1'b0, 1'b0}));
            end
            do_reset();
        end
    endtask

    // Reference: expected per-cycle state/strobe list for one legal instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z,
                         input int fw, input int mw, output int ret);
        logic [2:0] alu;
        q.delete();
        ret = 1;
        case (fn)
            6'h22:   alu = 3'd1;
            6'h24:   alu = 3'd2;
            6'h25:   alu = 3'd3;
            6'h26:   alu = 3'd4;
            default: alu = 3'd0;
        endcase
        for (int i = 0; i < fw; i++) q.push_back('{3'd1, 1'b0, M_MR});
        q.push_back('{3'd1, 1'b1, M_MR | M_IRL | M_PCI});
        q.push_back('{3'd2, 1'($urandom_range(0, 1)), M_AB});
        case (op)
            6'h00: begin
                q.push_back('{3'd3, 1'($urandom_range(0, 1)), {11'd0, alu}});
                q.push_back('{3'd5, 1'($urandom_range(0, 1)), M_RW});
            end
            6'h08: begin
                q.push_back('{3'd3, 1'($urandom_range(0, 1)), M_S2});
                q.push_back('{3'd5, 1'($urandom_range(0, 1)), M_RW});
            end
            6'h23, 6'h2B: begin
                logic [13:0] m;
                m = (op == 6'h23) ? M_MR : M_MW;
                q.push_back('{3'd3, 1'($urandom_range(0, 1)), M_S2});
                for (int i = 0; i < mw; i++) q.push_back('{3'd4, 1'b0, m});
                q.push_back('{3'd4, 1'b1, m});
                if (op == 6'h23) q.push_back('{3'd5, 1'($urandom_range(0, 1)), M_RW | M_WSM});
            end
            6'h04: q.push_back('{3'd3, 1'($urandom_range(0, 1)), M_S1 | (z ? M_PCL : 14'd0)});
            default: q.push_back('{3'd3, 1'($urandom_range(0, 1)), M_S1 | M_PCL});
        endcase
    endtask

    task automatic run_q();
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy;
            #1;
            check("rand step", 32'({bus.state, strobes_now()}), 32'({q[i].st, q[i].sb}));
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic sw_reset_midmem();
        bus.opcode    = 6'h2B;
        bus.opcodeALU = 11'd0;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        bus.mem_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("sw in mem", 32'({bus.state, bus.mem_write}), 32'({3'd4, 1'b1}));
        #2 reset = 1'b1;
        #1;
        check("async drop", 32'({bus.state, bus.mem_write, bus.mem_read}), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("post rst idle", 32'(bus.state), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("post rst fetch", 32'(bus.state), 32'd1);
        check("post rst count", bus.instr_count, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cnt;
        int ret;
        logic [5:0] op, fn;
        vt = '{
            '{6'h00, 6'h20, 0, 0,  0,  4, 3'd1, 1, 0, 0, 3'd0, 0},
            '{6'h00, 6'h22, 0, 2,  0,  6, 3'd1, 1, 0, 0, 3'd1, 0},
            '{6'h00, 6'h24, 1, 0,  0,  4, 3'd1, 1, 0, 0, 3'd2, 0},
            '{6'h00, 6'h25, 0, 1,  0,  5, 3'd1, 1, 0, 0, 3'd3, 0},
            '{6'h00, 6'h26, 0, 0,  0,  4, 3'd1, 1, 0, 0, 3'd4, 0},
            '{6'h08, 6'h00, 0, 0,  0,  4, 3'd1, 1, 0, 0, 3'd0, 0},
            '{6'h23, 6'h00, 0, 0,  3,  8, 3'd1, 1, 0, 0, 3'd0, 0},
            '{6'h2B, 6'h00, 0, 1,  1,  6, 3'd1, 1, 0, 0, 3'd0, 0},
            '{6'h04, 6'h00, 1, 0,  0,  3, 3'd1, 1, 0, 0, 3'd0, 1},
            '{6'h04, 6'h00, 0, 0,  0,  3, 3'd1, 1, 0, 0, 3'd0, 0},
            '{6'h02, 6'h00, 0, 0,  0,  3, 3'd1, 1, 0, 0, 3'd0, 1},
            '{6'h23, 6'h00, 0, 14, 0, 19, 3'd1, 1, 0, 0, 3'd0, 0},
            '{6'h2B, 6'h00, 0, 0, 14, 18, 3'd1, 1, 0, 0, 3'd0, 0},
            '{6'h15, 6'h00, 0, 0,  0,  2, 3'd6, 0, 1, 0, 3'd7, 0},
            '{6'h00, 6'h3F, 0, 0,  0,  3, 3'd6, 0, 1, 0, 3'd0, 0},
            '{6'h3F, 6'h00, 0, 0,  0,  2, 3'd6, 0, 0, 0, 3'd7, 0},
            '{6'h00, 6'h20, 0, 15, 0, 15, 3'd6, 0, 0, 1, 3'd7, 0},
            '{6'h23, 6'h00, 0, 0, 15, 18, 3'd6, 0, 0, 1, 3'd0, 0}
        };
        bus.opcode    = 6'd0;
        bus.opcodeALU = 11'd0;
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        do_reset();

        foreach (vt[i]) run_vec(i, vt[i]);

        exp_cnt = bus.instr_count;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h08;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                default: op = 6'h02;
            endcase
            case ($urandom_range(0, 4))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                default: fn = 6'h26;
            endcase
            bus.opcode    = op;
            bus.opcodeALU = (op == 6'h00) ? {5'($urandom), fn} : 11'($urandom);
            bus.alu_zero  = 1'($urandom_range(0, 1));
            build(op, bus.opcodeALU[5:0], bus.alu_zero,
                  $urandom_range(0, 3), $urandom_range(0, 3), ret);
            run_q();
            exp_cnt = exp_cnt + 32'(ret);
            check("rand count", bus.instr_count, exp_cnt);
        end

        sw_reset_midmem();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
